// File: rtl/parity_stream_checker.sv
// Streamed word parity checker: one-beat output register, per-frame
// error aggregation and saturating error statistics.
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_error,
  output logic              out_last,
  output logic              out_frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              sticky_err
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             acc;
  logic             accept;
  logic             gen;
  logic             err;
  logic             acc_before;
  logic             frame_err;
  logic [CNT_W-1:0] cnt_base;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign gen        = (^in_data) ^ mode;
  assign err        = in_parity != gen;
  assign acc_before = (state == ACTIVE) && acc;
  assign frame_err  = in_last && (acc_before || err);
  // clear takes effect before an erroring beat on the same edge is counted
  assign cnt_base   = clr_stats ? '0 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_parity    <= 1'b0;
      out_error     <= 1'b0;
      out_last      <= 1'b0;
      out_frame_err <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_data      <= in_data;
      out_parity    <= gen;
      out_error     <= err;
      out_last      <= in_last;
      out_frame_err <= frame_err;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        state <= IDLE;
        acc   <= 1'b0;
      end else begin
        state <= ACTIVE;
        acc   <= acc_before || err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      sticky_err <= 1'b0;
    end else if (accept && err) begin
      sticky_err <= 1'b1;
      err_count  <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
    end else if (clr_stats) begin
      sticky_err <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Parametrised, pipelined parity generator/checker for a streamed word interface. Each accepted beat carries a DATA_W-bit word and a received parity bit. The block regenerates parity under a per-beat even/odd mode and flags word errors. It also aggregates errors per frame, delimited by a last flag. It sits on the receive side of a datapath between a producer and a consumer, with valid/ready on both sides, and exposes saturating error statistics.

## Interface
- DATA_W, 8, word width in bits (≥1)
- CNT_W, 8, width of saturating error counter (≥1)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  parity mode for the beat being accepted: 0 = even, 1 = odd
- clr_stats  input  1  synchronous clear of err_count and sticky_err
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  DATA_W  word
- in_parity  input  1  received parity bit
- in_last  input  1  final word of frame
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_data  output  DATA_W  registered copy of in_data
- out_parity  output  1  generated parity for out_data under its mode
- out_error  output  1  word parity error
- out_last  output  1  registered in_last
- out_frame_err  output  1  on the out_last beat: any word error in that frame; 0 on other beats
- err_count  output  CNT_W  word errors since reset or clear, saturating
- sticky_err  output  1  set on any word error, held until clr_stats or reset

## Operation
- Beat accepted when in_valid && in_ready. Result beat transferred when out_valid && out_ready.
- gen = (^in_data) ^ mode. Even mode: data ones plus parity is even. Odd mode: that total is odd.
- Word error: err = in_parity != gen. out_parity = gen.
- mode is sampled only at acceptance. Mode changes mid-frame are legal; each word uses its own mode.
- Frame FSM with two states:
  - IDLE: no frame open. Any accepted beat with in_last=0 goes to ACTIVE and sets acc = err.
  - ACTIVE: each accepted beat does acc |= err. A beat with in_last=1 goes to IDLE.
  - A beat with in_last=1 accepted in IDLE is a one-word frame and stays in IDLE.
- out_frame_err = (acc_before | err) on a last beat, else 0. The accumulator clears when a last beat is accepted.
- Statistics:
  - Each accepted beat with err=1 increments err_count and sets sticky_err.
  - err_count holds at 2^CNT_W−1 once reached.
  - Counters update at acceptance, not at output transfer.
  - When clr_stats coincides with an erroring accept, the clear applies first and the beat is then counted: err_count=1, sticky_err=1.
- Output register holds one beat. in_ready = !out_valid || out_ready, so full throughput is possible with combinational ready from the output stage only.
- out_* fields hold stable while out_valid && !out_ready.

## Timing
- Latency: accept on edge N makes the result visible with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0. No beat is dropped or duplicated, and order is preserved.
- out_valid goes to 0 after a transfer with no new accept in the same cycle.
- Reset (asserted asynchronously, any time, including mid-frame or with a held output):
  - out_valid=0, out_data=0, out_parity=0, out_error=0, out_last=0, out_frame_err=0.
  - err_count=0, sticky_err=0, FSM=IDLE, accumulator=0.
  - in_ready=1 while reset is deasserted and out_valid=0.
- After reset deassertion, the first accepted beat starts a new frame. A partial frame from before reset is discarded.

## Test plan
- DATA_W=8, mode=0, in_data=0x96, in_parity=0 → out_error=0, out_parity=0; repeat with in_parity=1 → out_error=1, err_count=1, sticky_err=1.
- mode=1, in_data=0x96, in_parity=1 → out_error=0, out_parity=1; in_data=0x07, in_parity=1 → out_error=1.
- Backpressure: two back-to-back beats with out_ready=0 for 3 cycles → first beat held stable, in_ready=0, second beat waits. After out_ready=1 both appear in order, 1 cycle apart.
- Frames: 3 words with word 2 bad and in_last on word 3 → out_frame_err=0,0,1. Next 2-word clean frame → 0,0. A single beat with in_last=1 and a bad word → out_frame_err=1.
- Saturation: CNT_W=2, 5 erroring beats → err_count=3, sticky_err=1. clr_stats alone → 0,0. clr_stats with an erroring accept → 1,1.
- Reset mid-frame: open a frame with a bad word and out_valid=1, then pulse rst_n low → all outputs 0 immediately. A subsequent clean one-word frame → out_frame_err=0.
